// File: rtl/spi_reg_slave.sv
// SPI register slave: 16x8 register file, command byte {rd, xxx, addr[3:0]} then auto-incrementing data bytes.
// Writes land one clk after the 8th sample edge; no backpressure, clk must run at least 8x SCLK.
module spi_reg_slave #(
    parameter logic CPOL        = 1'b0,
    parameter logic CPHA        = 1'b0,
    parameter logic DEFAULT_VAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         SPI_SCLK,
    input  logic         CS,
    input  logic         MOSI,
    output logic         MISO,
    output logic         busy,
    output logic         wr_strobe,
    output logic [3:0]   wr_addr,
    output logic [7:0]   wr_data,
    input  logic         loc_we,
    input  logic [3:0]   loc_addr,
    input  logic [7:0]   loc_data,
    output logic [127:0] reg_out,
    output logic         frame_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_d, cs_d;
    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic       sample_edge, shift_edge, cs_fall, cs_rise;

    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sr, tx_sr, tx_hold;
    logic [7:0] byte_val;
    logic [3:0] addr;
    logic       is_read, byte_done, first_shift;
    logic [7:0] regs [16];

    // CS synchronizer resets low so a CS held low across reset is not seen as a
    // new frame; the next real frame needs CS to go high and fall again.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= {2{CPOL}};
            sclk_d    <= CPOL;
            cs_sync   <= 2'b00;
            cs_d      <= 1'b0;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[0], SPI_SCLK};
            sclk_d    <= sclk_sync[1];
            cs_sync   <= {cs_sync[0], CS};
            cs_d      <= cs_sync[1];
            mosi_sync <= {mosi_sync[0], MOSI};
        end
    end

    assign sclk_s      = sclk_sync[1];
    assign cs_s        = cs_sync[1];
    assign mosi_s      = mosi_sync[1];
    assign sclk_rise   = sclk_s & ~sclk_d;
    assign sclk_fall   = ~sclk_s & sclk_d;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_s & cs_d;
    assign cs_rise     = cs_s & ~cs_d;
    assign byte_val    = {rx_sr[6:0], mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            rx_sr       <= 8'h00;
            tx_sr       <= 8'h00;
            tx_hold     <= 8'h00;
            addr        <= 4'h0;
            is_read     <= 1'b0;
            byte_done   <= 1'b0;
            first_shift <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= 4'h0;
            wr_data     <= 8'h00;
            frame_err   <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (loc_we) regs[loc_addr] <= loc_data;

            if (state == IDLE) begin
                if (cs_fall) begin
                    state       <= CMD;
                    bit_cnt     <= 3'd0;
                    tx_sr       <= 8'h5A;
                    byte_done   <= 1'b0;
                    first_shift <= 1'b1;
                end
            end else if (cs_rise) begin
                state   <= IDLE;
                bit_cnt <= 3'd0;
                if (bit_cnt != 3'd0) frame_err <= 1'b1;
            end else begin
                // The shift edge after a completed byte presents the staged next byte.
                if (shift_edge) begin
                    first_shift <= 1'b0;
                    byte_done   <= 1'b0;
                    if (byte_done)
                        tx_sr <= tx_hold;
                    else if (!(CPHA && first_shift))
                        tx_sr <= {tx_sr[6:0], 1'b0};
                end
                if (sample_edge) begin
                    rx_sr   <= byte_val;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_done <= 1'b1;
                        if (state == CMD) begin
                            state   <= DATA;
                            is_read <= byte_val[7];
                            if (byte_val[7]) begin
                                tx_hold <= regs[byte_val[3:0]];
                                addr    <= byte_val[3:0] + 4'd1;
                            end else begin
                                tx_hold <= 8'h00;
                                addr    <= byte_val[3:0];
                            end
                        end else if (is_read) begin
                            tx_hold <= regs[addr];
                            addr    <= addr + 4'd1;
                        end else begin
                            // Placed after the local write so it wins on an address clash.
                            regs[addr] <= byte_val;
                            wr_strobe  <= 1'b1;
                            wr_addr    <= addr;
                            wr_data    <= byte_val;
                            addr       <= addr + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign MISO = (state == IDLE || cs_s) ? DEFAULT_VAL : tx_sr[7];
    assign busy = (state != IDLE);

    for (genvar g = 0; g < 16; g++) begin : g_reg_out
        assign reg_out[g*8 +: 8] = regs[g];
    end

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 The block SHALL have these parameters:
- CPOL, default 0, idle SCLK level.
- CPHA, default 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- DEFAULT_VAL, default 1'b0, MISO level while CS is high.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- SPI_SCLK, in, 1: SPI clock from master.
- CS, in, 1: chip select, active low.
- MOSI, in, 1: serial data in.
- MISO, out, 1: serial data out.
- busy, out, 1: high while a frame is in progress (CS low, synchronized).
- wr_strobe, out, 1: one-cycle pulse on SPI register write.
- wr_addr, out, 4: address of the write.
- wr_data, out, 8: data of the write.
- loc_we, in, 1: local write enable.
- loc_addr, in, 4: local write address.
- loc_data, in, 8: local write data.
- reg_out, out, 128: register file, reg[n] at bits 8n+7:8n.
- frame_err, out, 1: one-cycle pulse on truncated byte.

Function
REQ-004 SPI_SCLK, CS and MOSI SHALL each pass through a 2-FF synchronizer; edges are detected in the clk domain; clk SHALL be at least 8x SCLK.
REQ-005 Leading edge SHALL be rising for CPOL=0 and falling for CPOL=1. The sample edge is the leading edge if CPHA=0, else the trailing edge. The shift edge is the other edge.
REQ-006 The state machine SHALL have states IDLE, CMD and DATA.
- IDLE->CMD on synchronized CS fall.
- CMD->DATA after the 8th sample edge.
- Any state->IDLE on synchronized CS rise.
REQ-007 All bits SHALL be MSB first; a 3-bit counter counts sample edges per byte.
REQ-008 Command byte format:
- bit7 = 1 is read, 0 is write.
- bits3:0 = start address.
- bits6:4 are ignored.
REQ-009 During the command byte, MISO SHALL shift out the signature 8'h5A.
REQ-010 Write frame: each complete data byte SHALL be written to reg[addr]. One clk after the 8th sample edge, wr_strobe pulses with wr_addr/wr_data. Then addr increments.
REQ-011 Read frame: at each byte boundary the tx shift register SHALL load reg[addr], then addr increments. The first data byte is reg[start address].
REQ-012 Address SHALL wrap 4'hF -> 4'h0 in both directions of transfer.
REQ-013 CPHA=0: MISO SHALL present bit7 from CS assertion and advance on each shift edge. The shift edge after a byte's 8th sample edge presents bit7 of the next byte.
REQ-014 CPHA=1: the first shift edge of a frame SHALL present bit7 without advancing; subsequent shift edges advance.
REQ-015 MISO SHALL equal DEFAULT_VAL while synchronized CS is high.
REQ-016 CS rise with a nonzero bit count SHALL discard the partial byte, perform no write, and pulse frame_err for one cycle.
REQ-017 A frame of only a write command, or a CS pulse with no SCLK edges, SHALL cause no write and no frame_err.
REQ-018 loc_we SHALL write reg[loc_addr] next cycle. If it coincides with an SPI write to the same address, the SPI write wins. A different address writes both.
REQ-019 A read byte already loaded in the shift register SHALL NOT change if the register is later written.
REQ-020 SCLK edges while CS is high SHALL be ignored.

Reset
REQ-021 While rst is high, the block SHALL hold:
- state IDLE, all 16 registers 8'h00, counters 0;
- busy, wr_strobe and frame_err low;
- wr_addr 0, wr_data 0;
- MISO = DEFAULT_VAL.
REQ-022 rst asserted mid-frame SHALL abort the frame; the block ignores traffic until the next CS fall after rst is deasserted.

Verification
REQ-023 Mode 0: frame 8'h03, 8'hAA, 8'h55 -> wr_strobe twice, reg[3]=AA, reg[4]=55; MISO during the command byte = 5A.
REQ-024 Mode 0: loc write reg[3]=C9, then frame 8'h83 plus two dummy bytes -> master receives 5A, C9, reg[4].
REQ-025 CPOL=1, CPHA=1: frame 8'h0F, 8'h11, 8'h22 -> reg[F]=11, reg[0]=22 (wrap); a read from F returns 11, 22.
REQ-026 Write command plus 5 data bits, then CS high -> frame_err pulses once; registers unchanged.
REQ-027 Same-cycle SPI write of reg[2]=77 and loc_we reg[2]=33 -> reg[2]=77.
REQ-028 rst pulsed mid data byte -> all outputs at reset values; the next full frame works normally.
